// File: rtl/apb_gpio_if.sv
// APB3 bus bundle between the AHB-to-APB bridge (master) and a GPIO slave.
// The master drives the select, address, control and write data; the slave returns PRDATA, PREADY and PSLVERR.
interface apb_gpio_if;
  logic [15:0] PSEL;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB3 GPIO slave. It has programmable wait states, synchronised inputs and per-bit edge/level interrupts.
// Define APB_GPIO_OE_EN to add the RW output-enable register at 0x14. Without it, GPIO_OE is tied to all ones.
module apb_gpio_slave #(
  parameter int IO_NUM      = 8,
  parameter int WAIT_STATES = 0,
  parameter int PSEL_BIT    = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_gpio_if.slave         apb,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic              INT
);

  localparam logic [2:0] WS           = 3'(WAIT_STATES);
  localparam logic [7:0] OFF_DATA_OUT = 8'h00;
  localparam logic [7:0] OFF_DATA_IN  = 8'h04;
  localparam logic [7:0] OFF_INT_EN   = 8'h08;
  localparam logic [7:0] OFF_INT_TYPE = 8'h0C;
  localparam logic [7:0] OFF_INT_STAT = 8'h10;
`ifdef APB_GPIO_OE_EN
  localparam logic [7:0] OFF_OE       = 8'h14;
`endif

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              sel, ready, complete, addr_err, wr_en;
  logic [7:0]        off;
  logic [31:0]       rd_data;
  logic [IO_NUM-1:0] data_out, int_en, int_type, int_stat;
  logic [IO_NUM-1:0] sync1, sync2, prev, int_set, w1c;
  logic              int_q;
  logic              unused_bits;

  assign sel = apb.PSEL[PSEL_BIT];
  assign off = apb.PADDR[7:0];

  // Only PSEL[PSEL_BIT], PADDR[7:0] and PWDATA[IO_NUM-1:0] matter. The rest is folded here.
  assign unused_bits = ^{apb.PSEL, apb.PADDR, apb.PWDATA};

  // Transfer FSM: next state, wait counter and ready.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !apb.PENABLE) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_nxt = IDLE;
        end else if (!apb.PENABLE) begin
          cnt_nxt = '0;  // a fresh setup phase restarts the wait count
        end else if (cnt == WS) begin
          ready     = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A transfer that coincides with reset is abandoned rather than completed.
  assign complete = ready & ~PRESET;
  assign wr_en    = complete & apb.PWRITE & ~addr_err;

  // Address decode and read mux. Read data is zero-extended to 32 bits.
  always_comb begin
    addr_err = 1'b0;
    rd_data  = '0;
    case (off)
      OFF_DATA_OUT: rd_data[IO_NUM-1:0] = data_out;
      OFF_DATA_IN:  rd_data[IO_NUM-1:0] = sync2;
      OFF_INT_EN:   rd_data[IO_NUM-1:0] = int_en;
      OFF_INT_TYPE: rd_data[IO_NUM-1:0] = int_type;
      OFF_INT_STAT: rd_data[IO_NUM-1:0] = int_stat;
`ifdef APB_GPIO_OE_EN
      OFF_OE:       rd_data[IO_NUM-1:0] = GPIO_OE;
`endif
      default:      addr_err = 1'b1;
    endcase
  end

  assign apb.PREADY  = complete;
  assign apb.PSLVERR = complete & addr_err;
  assign apb.PRDATA  = (complete && !apb.PWRITE && !addr_err) ? rd_data : '0;

  assign w1c     = (wr_en && off == OFF_INT_STAT) ? apb.PWDATA[IO_NUM-1:0] : '0;
  assign int_set = int_en & ((int_type & sync2 & ~prev) | (~int_type & sync2));

  always_ff @(posedge PCLK) begin
    // NOTE: all state uses non-blocking assignment. Every flop then samples pre-edge values, like hardware does.
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out <= '0;
      int_en   <= '0;
      int_type <= '0;
      int_stat <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      int_q    <= 1'b0;
    end else begin
      sync1    <= GPIO_IN;
      sync2    <= sync1;
      prev     <= sync2;
      // A new event outranks a write-1-to-clear on the same edge.
      int_stat <= (int_stat & ~w1c) | int_set;
      int_q    <= |int_stat;
      if (wr_en) begin
        case (off)
          OFF_DATA_OUT: data_out <= apb.PWDATA[IO_NUM-1:0];
          OFF_INT_EN:   int_en   <= apb.PWDATA[IO_NUM-1:0];
          OFF_INT_TYPE: int_type <= apb.PWDATA[IO_NUM-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef APB_GPIO_OE_EN
  logic [IO_NUM-1:0] oe;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      oe <= '0;
    end else if (wr_en && off == OFF_OE) begin
      oe <= apb.PWDATA[IO_NUM-1:0];
    end
  end

  assign GPIO_OE = oe;
`else
  assign GPIO_OE = '1;
`endif

  assign GPIO_OUT = data_out;
  assign INT      = int_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave. It drives two instances (WAIT_STATES=0 on PSEL[1], WAIT_STATES=3 on PSEL[2]) from one APB stream.
// Build with APB_GPIO_OE_EN defined or undefined. The OE expectations follow the same macro.
module tb_apb_gpio_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [15:0] psel;
  logic [31:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out0, gpio_oe0, gpio_out3, gpio_oe3;
  logic        int0, int3;

  int errors = 0;
  int checks = 0;

`ifdef APB_GPIO_OE_EN
  localparam logic [7:0] OE_RESET = 8'h00;
`else
  localparam logic [7:0] OE_RESET = 8'hFF;
`endif

  apb_gpio_if bus0();
  apb_gpio_if bus3();

  assign bus0.PSEL    = psel;
  assign bus0.PADDR   = paddr;
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PSEL    = psel;
  assign bus3.PADDR   = paddr;
  assign bus3.PENABLE = penable;
  assign bus3.PWRITE  = pwrite;
  assign bus3.PWDATA  = pwdata;

  apb_gpio_slave #(.IO_NUM(8), .WAIT_STATES(0), .PSEL_BIT(1)) dut0 (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus0),
    .GPIO_IN  (gpio_in),
    .GPIO_OUT (gpio_out0),
    .GPIO_OE  (gpio_oe0),
    .INT      (int0)
  );

  apb_gpio_slave #(.IO_NUM(8), .WAIT_STATES(3), .PSEL_BIT(2)) dut3 (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus3),
    .GPIO_IN  (gpio_in),
    .GPIO_OUT (gpio_out3),
    .GPIO_OE  (gpio_oe3),
    .INT      (int3)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One complete APB transfer: a setup cycle, then access cycles until PREADY, with a bounded wait.
  task automatic apb_xfer(input bit slow, input logic [7:0] addr, input bit wr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits, output bit early_nz);
    bit done = 1'b0;
    waits = 0; early_nz = 1'b0; rdata = '0; err = 1'b0;
    @(posedge PCLK); #1;
    psel = slow ? 16'h0004 : 16'h0002;
    paddr = {24'h0, addr}; pwrite = wr; pwdata = wdata; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge PCLK);
      if ((slow ? bus3.PREADY : bus0.PREADY) === 1'b1) begin
        rdata = slow ? bus3.PRDATA : bus0.PRDATA;
        err   = slow ? bus3.PSLVERR : bus0.PSLVERR;
        done  = 1'b1;
      end else begin
        waits++;
        if ((slow ? bus3.PRDATA : bus0.PRDATA) !== 32'h0) early_nz = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    psel = '0; penable = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout addr=%h got no PREADY, required PREADY within 16 cycles", addr);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    checks++; if (bus0.PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready got=%b exp=0", bus0.PREADY); end
    checks++; if (bus0.PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata got=%h exp=0", bus0.PRDATA); end
    checks++; if (bus0.PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr got=%b exp=0", bus0.PSLVERR); end
    checks++; if (gpio_out0 !== 8'h00) begin errors++; $display("FAIL rst_gpio_out got=%h exp=00", gpio_out0); end
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL rst_int got=%b exp=0", int0); end
    checks++; if (gpio_oe0 !== OE_RESET) begin errors++; $display("FAIL rst_gpio_oe got=%h exp=%h", gpio_oe0, OE_RESET); end
    checks++; if (bus3.PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready3 got=%b exp=0", bus3.PREADY); end
  endtask

  task automatic test_ws0();
    logic [31:0] rd; logic err; int w; bit enz;
    apb_xfer(1'b0, 8'h00, 1'b1, 32'hA5, rd, err, w, enz);
    checks++; if (w !== 0) begin errors++; $display("FAIL ws0_wr_waits got=%0d exp=0", w); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ws0_wr_err got=%b exp=0", err); end
    checks++; if (gpio_out0 !== 8'hA5) begin errors++; $display("FAIL ws0_gpio_out got=%h exp=a5", gpio_out0); end
    checks++; if (gpio_out3 !== 8'h00) begin errors++; $display("FAIL ws0_other_slave got=%h exp=00", gpio_out3); end
    apb_xfer(1'b0, 8'h00, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h000000A5) begin errors++; $display("FAIL ws0_rd_data got=%h exp=000000a5", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ws0_rd_err got=%b exp=0", err); end
    checks++; if (w !== 0) begin errors++; $display("FAIL ws0_rd_waits got=%0d exp=0", w); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w; bit enz;
    apb_xfer(1'b1, 8'h00, 1'b1, 32'h5A, rd, err, w, enz);
    checks++; if (w !== 3) begin errors++; $display("FAIL ws3_wr_waits got=%0d exp=3", w); end
    checks++; if (gpio_out3 !== 8'h5A) begin errors++; $display("FAIL ws3_gpio_out got=%h exp=5a", gpio_out3); end
    apb_xfer(1'b1, 8'h00, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (w !== 3) begin errors++; $display("FAIL ws3_rd_waits got=%0d exp=3", w); end
    checks++; if (enz !== 1'b0) begin errors++; $display("FAIL ws3_early_prdata got=%b exp=0", enz); end
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL ws3_rd_data got=%h exp=0000005a", rd); end
  endtask

  task automatic test_input_sync();
    logic [31:0] rd; logic err; int w; bit enz;
    // Change the input in the same cycle as the setup. The access cycle then sees only one edge.
    @(posedge PCLK); #1;
    gpio_in = 8'h3C; psel = 16'h0002; paddr = 32'h04; pwrite = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    checks++; if (bus0.PREADY !== 1'b1) begin errors++; $display("FAIL sync_1edge_ready got=%b exp=1", bus0.PREADY); end
    checks++; if (bus0.PRDATA !== 32'h0) begin errors++; $display("FAIL sync_1edge_data got=%h exp=0", bus0.PRDATA); end
    @(posedge PCLK); #1;
    psel = '0; penable = 1'b0;
    apb_xfer(1'b0, 8'h04, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL sync_data_in got=%h exp=0000003c", rd); end
    apb_xfer(1'b0, 8'h04, 1'b1, 32'hFF, rd, err, w, enz);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL data_in_wr_err got=%b exp=0", err); end
    apb_xfer(1'b0, 8'h04, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL data_in_ro got=%h exp=0000003c", rd); end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd; logic err; int w; bit enz;
    apb_xfer(1'b0, 8'h08, 1'b1, 32'h01, rd, err, w, enz);
    apb_xfer(1'b0, 8'h0C, 1'b1, 32'h01, rd, err, w, enz);
    apb_xfer(1'b0, 8'h10, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL int_stat_idle got=%h exp=0", rd); end
    // Rising edge on bit 0: sync1, sync2, then INT_STAT on the third edge, and INT on the fourth.
    @(posedge PCLK); #1;
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL int_early got=%b exp=0", int0); end
    @(posedge PCLK);
    @(negedge PCLK);
    checks++; if (int0 !== 1'b1) begin errors++; $display("FAIL int_registered got=%b exp=1", int0); end
    apb_xfer(1'b0, 8'h10, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL int_stat_set got=%h exp=00000001", rd); end
    // The next rising edge is timed so that it lands on the W1C commit edge.
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    #1 gpio_in[0] = 1'b1;
    apb_xfer(1'b0, 8'h10, 1'b1, 32'h01, rd, err, w, enz);
    apb_xfer(1'b0, 8'h10, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL int_set_wins got=%h exp=00000001", rd); end
    apb_xfer(1'b0, 8'h08, 1'b1, 32'h00, rd, err, w, enz);
    apb_xfer(1'b0, 8'h10, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL int_en_clear_keeps got=%h exp=00000001", rd); end
    apb_xfer(1'b0, 8'h10, 1'b1, 32'h01, rd, err, w, enz);
    apb_xfer(1'b0, 8'h10, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL int_w1c got=%h exp=0", rd); end
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL int_cleared got=%b exp=0", int0); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w; bit enz;
    apb_xfer(1'b0, 8'h20, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err20_rd_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err20_rd_data got=%h exp=0", rd); end
    checks++; if (w !== 0) begin errors++; $display("FAIL err20_waits got=%0d exp=0", w); end
    apb_xfer(1'b0, 8'h20, 1'b1, 32'h77, rd, err, w, enz);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err20_wr_err got=%b exp=1", err); end
    checks++; if (gpio_out0 !== 8'hA5) begin errors++; $display("FAIL err20_no_write got=%h exp=a5", gpio_out0); end
    apb_xfer(1'b0, 8'h02, 1'b1, 32'hFF, rd, err, w, enz);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err02_wr_err got=%b exp=1", err); end
    checks++; if (gpio_out0 !== 8'hA5) begin errors++; $display("FAIL err02_no_write got=%h exp=a5", gpio_out0); end
    apb_xfer(1'b0, 8'h02, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err02_rd_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err02_rd_data got=%h exp=0", rd); end
    apb_xfer(1'b0, 8'h08, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_int_en_kept got=%h exp=0", rd); end
    apb_xfer(1'b0, 8'h14, 1'b1, 32'hF0, rd, err, w, enz);
`ifdef APB_GPIO_OE_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oe_wr_err got=%b exp=0", err); end
    checks++; if (gpio_oe0 !== 8'hF0) begin errors++; $display("FAIL oe_drive got=%h exp=f0", gpio_oe0); end
    apb_xfer(1'b0, 8'h14, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'hF0) begin errors++; $display("FAIL oe_rd got=%h exp=000000f0", rd); end
`else
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oe_off_err got=%b exp=1", err); end
    checks++; if (gpio_oe0 !== 8'hFF) begin errors++; $display("FAIL oe_tied got=%h exp=ff", gpio_oe0); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w; bit enz;
    bit saw_ready = 1'b0;
    @(posedge PCLK); #1;
    psel = 16'h0004; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'hFF; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++; if (bus3.PREADY !== 1'b0) begin errors++; $display("FAIL rstmid_pready_in_reset got=%b exp=0", bus3.PREADY); end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    // Holding the stale access phase must not revive the abandoned transfer.
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (bus3.PREADY !== 1'b0) saw_ready = 1'b1;
    end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pready got=1 exp=0"); end
    checks++; if (gpio_out3 !== 8'h00) begin errors++; $display("FAIL rstmid_gpio_out got=%h exp=00", gpio_out3); end
    checks++; if (gpio_out0 !== 8'h00) begin errors++; $display("FAIL rstmid_gpio_out0 got=%h exp=00", gpio_out0); end
    @(posedge PCLK); #1;
    psel = '0; penable = 1'b0;
    apb_xfer(1'b1, 8'h00, 1'b1, 32'h3C, rd, err, w, enz);
    checks++; if (w !== 3) begin errors++; $display("FAIL rstmid_next_waits got=%0d exp=3", w); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_next_err got=%b exp=0", err); end
    checks++; if (gpio_out3 !== 8'h3C) begin errors++; $display("FAIL rstmid_next_out got=%h exp=3c", gpio_out3); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w; bit enz;
    @(posedge PCLK); #1;
    psel = 16'h0002; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h11; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    checks++; if (bus0.PREADY !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%b exp=1", bus0.PREADY); end
    @(posedge PCLK); #1;
    paddr = 32'h08; pwdata = 32'h03; penable = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    checks++; if (bus0.PREADY !== 1'b1) begin errors++; $display("FAIL b2b_second_ready got=%b exp=1", bus0.PREADY); end
    @(posedge PCLK); #1;
    psel = '0; penable = 1'b0;
    checks++; if (gpio_out0 !== 8'h11) begin errors++; $display("FAIL b2b_gpio_out got=%h exp=11", gpio_out0); end
    apb_xfer(1'b0, 8'h08, 1'b0, 32'h0, rd, err, w, enz);
    checks++; if (rd !== 32'h03) begin errors++; $display("FAIL b2b_int_en got=%h exp=00000003", rd); end
  endtask

  initial begin
    PRESET = 1'b1; psel = '0; paddr = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; gpio_in = '0;
    test_reset();
    test_ws0();
    test_wait_states();
    test_input_sync();
    test_interrupt();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
- APB3 slave that consumes the PSEL/PADDR/PENABLE/PWRITE/PWDATA stream produced by the BFM AHB-to-APB stage. It returns PRDATA, PREADY and PSLVERR to that stage.
- Provides a GPIO register file: output data, synchronised input data, and per-bit interrupt enable, type and status.
- Adds a programmable number of wait states. This lets the bench exercise the PREADY stretch and PSLVERR paths of the bridge.

Parameters:
- IO_NUM, 8, number of GPIO bits (1..32).
- WAIT_STATES, 0, extra access-phase cycles before PREADY is asserted (0..7).
- PSEL_BIT, 1, index of the PSEL vector bit that selects this slave.

Ports:
- PCLK  in  1  sole clock.
- PRESET  in  1  reset.
- PSEL  in  16  slave selects; only PSEL[PSEL_BIT] is used.
- PADDR  in  32  byte address; PADDR[7:0] is decoded.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid with PREADY.
- GPIO_IN  in  IO_NUM  asynchronous inputs.
- GPIO_OUT  out  IO_NUM  output data register.
- GPIO_OE  out  IO_NUM  output enables.
- INT  out  1  OR of INT_STAT.

Interface (already decided): one clock; reset is synchronous and active-high. The clock is PCLK and the reset is PRESET.

Behaviour:
- Reset: the following are 0.
  - All registers.
  - Synchroniser flops.
  - Wait counter.
  - PRDATA, PREADY, PSLVERR, GPIO_OUT, INT.
- Reset asserted mid-transfer: the transfer is abandoned, no write commits, and PREADY is 0 on the next edge.
- Transfer FSM, with sel = PSEL[PSEL_BIT]:
  - IDLE -> ACCESS on sel & !PENABLE (setup phase); wait counter cleared to 0.
  - In ACCESS with sel & PENABLE: PREADY = (cnt == WAIT_STATES), combinational from cnt. While PREADY=0, cnt increments each cycle.
  - The cycle with sel & PENABLE & PREADY completes the transfer. FSM returns to IDLE; a back-to-back setup re-enters ACCESS.
  - sel dropping in ACCESS without completion: return to IDLE, no commit.
  - PREADY, PRDATA and PSLVERR are 0 whenever not in a completing cycle.
- Latency: a transfer completes WAIT_STATES+1 cycles after the setup cycle.
- Register map (PADDR[7:0]); read data is zero-extended from IO_NUM:
  - 0x00 DATA_OUT: RW, drives GPIO_OUT.
  - 0x04 DATA_IN: RO; writes are ignored without error.
  - 0x08 INT_EN: RW.
  - 0x0C INT_TYPE: RW; 1 = rising edge, 0 = level high.
  - 0x10 INT_STAT: read, write-1-to-clear.
  - 0x14 OE: see Optional Feature.
  - Any other offset, or PADDR[1:0] != 0: PSLVERR=1 in the completing cycle, PRDATA=0, no state change.
- Write commit: on the completing edge only.
- Input path:
  - GPIO_IN passes through a 2-flop synchroniser (sync2), then a third flop (prev).
  - DATA_IN reflects a GPIO_IN change 2 PCLK edges later.
- Interrupt set condition, per bit i: INT_EN[i] & (INT_TYPE[i] ? (sync2[i] & !prev[i]) : sync2[i]).
  - A set and a W1C clear on the same edge: set wins.
  - Clearing INT_EN does not clear INT_STAT.
- INT is registered: INT = |INT_STAT, one cycle after INT_STAT changes.

Optional Feature:
- Macro APB_GPIO_OE_EN.
- Defined:
  - Register 0x14 OE is RW, reset 0, and drives GPIO_OE.
- Undefined:
  - GPIO_OE is tied to all ones.
  - Offset 0x14 returns PSLVERR=1 like an unmapped address.

Test Plan:
- WAIT_STATES=0: write 0xA5 to 0x00 -> PREADY=1 in the first access cycle, GPIO_OUT=0xA5; read 0x00 -> PRDATA=0x000000A5, PSLVERR=0.
- WAIT_STATES=3: read 0x00 -> PREADY low for 3 access cycles and high on the 4th; PRDATA is 0 until then.
- Drive GPIO_IN=0x3C -> read of 0x04 returns 0x3C once 2 edges have elapsed; a read at 1 edge returns the old value.
- INT_EN=0x01, INT_TYPE=0x01, pulse GPIO_IN[0] 0->1 -> INT_STAT=0x01, INT=1 one cycle later. Write 0x01 to 0x10 on the same edge as a new rising edge -> INT_STAT stays 0x01 (set wins).
- Access offset 0x20 and offset 0x02 -> PSLVERR=1 with PREADY, PRDATA=0, no register changes. Offset 0x14 gives PSLVERR=1 only when APB_GPIO_OE_EN is undefined.
- PRESET asserted during the wait phase of a write of 0xFF to 0x00 -> GPIO_OUT stays 0, PREADY=0; the next transfer completes normally.
